result_packer: RTL
==================

// Module: result_packer
// PURPOSE
//   Downstream stage of the kernel array: waits until every lane's result is valid, snapshots all
//   lanes, then streams them two 16-bit lanes per 32-bit word into the host-bound 32x512 FIFO,
//   throttled by the FIFO's almost_full flag. Replaces ad-hoc SEND-state packing in the top level.
//   Signals completion with a one-cycle done pulse so the top FSM can return to IDLE.
// PARAMETERS
//   LANES   512  number of kernel lanes; even, >= 2
//   DW      16   width of one lane result; packed word width is 2*DW (32 at default)
//   CNT_W   $clog2(LANES/2)  word-counter width (derived, not overridden)
// PORTS
//   bus_clk           in   1          single clock, PCIe bus clock
//   srst              in   1          synchronous, active-high reset
//   start             in   1          pulse from top FSM on entry to EXEC; honoured only in IDLE
//   abort             in   1          host closed a device file; level, any state
//   res_data          in   LANES*DW   flattened results; lane i at [i*DW +: DW]
//   res_valid         in   LANES      per-lane result valid
//   fifo_almost_full  in   1          from host-bound FIFO
//   fifo_wr_en        out  1          FIFO write enable
//   fifo_din          out  2*DW       packed word {lane 2k+1, lane 2k}
//   busy              out  1          high in ARMED or SEND
//   done              out  1          one-cycle pulse after last word written
//   state             out  4          one-hot FSM state, for GPIO_LED display
// BEHAVIOUR
//   Reset (srst=1): state=IDLE(4'b0001), counter k=0, fifo_wr_en=0, done=0, busy=0; snapshot undefined.
//   FSM (registered, one-hot): IDLE 0001, ARMED 0010, SEND 0100, DONE 1000.
//    IDLE : start=1 -> ARMED. start in any other state is ignored.
//    ARMED: &res_valid=1 -> snapshot all lanes into register bank, k<=0, -> SEND (same edge).
//           Partial valid: stay in ARMED indefinitely.
//    SEND : fifo_wr_en = (state==SEND) && !fifo_almost_full (combinational from registered state);
//           fifo_din = {snap[2k+1], snap[2k]}, muxed from registered k; on each write k<=k+1.
//           Write with k==LANES/2-1 -> DONE; k not incremented past LANES/2-1.
//           almost_full=1: no write, k holds, state holds.
//    DONE : done=1 for this cycle only; -> IDLE unconditionally.
//   abort=1 (any state) or srst=1: next state IDLE, k<=0, no write in that cycle; srst has priority.
//   Latency (all lanes valid, FIFO never almost_full): start at cycle t -> ARMED t+1, first write
//     t+2, last write t+1+LANES/2, done at t+2+LANES/2. Exactly LANES/2 writes per transaction.
//   Snapshot isolates output from kernel changes: res_data/res_valid ignored outside ARMED.
//   Lane order on the wire: word k low half = lane 2k, high half = lane 2k+1 (matches receive unpack).
// STRUCTURE
//   Shared package: one-hot state constants (IDLE/ARMED/SEND/DONE, reused by top-level FSM), DW and
//     packed-word width constants, lane_slice(i) index helper.
//   One sub-module natural: lane_pair_mux (snapshot bank + k-indexed 2-lane read mux); FSM and
//     counter stay in result_packer.
// TESTING  (bench LANES=8, DW=16 unless stated)
//   1 start, res_valid=8'hFF, lanes=0x0000..0x0007, almost_full=0 -> 4 writes: 0x00010000,
//     0x00030002,0x00050004,0x00070006 on cycles t+2..t+5; done at t+6; state back to 0001.
//   2 start, res_valid=8'h7F for 10 cycles then 8'hFF -> state=0010 for those 10 cycles, no writes;
//     snapshot taken on the edge valid completes; then 4 writes as in 1.
//   3 almost_full high for 3 cycles after 2nd write -> wr_en=0 those cycles, fifo_din stable at word 2,
//     remaining words resume in order; total writes=4, no duplicate/skip.
//   4 abort asserted after 2nd write -> no further writes, state=0001 next cycle, no done; new start
//     then sends full 4 words starting from word 0.
//   5 start pulsed during SEND and DONE -> ignored; srst mid-SEND -> outputs at reset values next cycle.
//   6 LANES=512 default: change res_data after snapshot -> sent words equal captured values, 256 writes.

Source files
------------

// File: rtl/result_packer_pkg.sv
// Shared constants for the result packer and the top-level FSM that drives it.
// Includes the one-hot state encodings and the lane slicing helper.
package result_packer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'b0001;
  localparam state_t ST_ARMED = 4'b0010;
  localparam state_t ST_SEND  = 4'b0100;
  localparam state_t ST_DONE  = 4'b1000;

  localparam int DW_DEF = 16;
  localparam int WORD_W = 2 * DW_DEF;

  function automatic int lane_slice(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/result_packer_lane_pair_mux.sv
// Snapshot register bank for all lanes plus the k-indexed read mux.
// Output word k carries lane 2k in the low half and lane 2k+1 in the high half.
module lane_pair_mux
  import result_packer_pkg::*;
#(
  parameter int LANES = 512,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_capture,
  input  logic [LANES*DW-1:0]   i_res_data,
  input  logic [CNT_W-1:0]      i_k,
  output logic [2*DW-1:0]       o_word
);

  logic [2*DW-1:0] r_snap [LANES/2];

  // No reset on the bank: contents are only read after a capture.
  always_ff @(posedge i_clk) begin
    if (i_capture) begin
      for (int p = 0; p < LANES/2; p++) begin
        r_snap[p] <= i_res_data[lane_slice(2*p, DW) +: 2*DW];
      end
    end
  end

  assign o_word = r_snap[i_k];

endmodule

// File: rtl/result_packer.sv
// Waits for all lanes valid, snapshots them, then streams lane pairs into the
// host-bound FIFO under almost_full throttling; pulses done when finished.
//
//   state | meaning
//   IDLE  | waiting for start
//   ARMED | waiting for every lane valid, then snapshot
//   SEND  | one packed word per cycle while FIFO has room
//   DONE  | one-cycle completion pulse
module result_packer
  import result_packer_pkg::*;
#(
  parameter int LANES = 512,
  parameter int DW    = DW_DEF
) (
  input  logic                  i_bus_clk,
  input  logic                  i_srst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [LANES*DW-1:0]   i_res_data,
  input  logic [LANES-1:0]      i_res_valid,
  input  logic                  i_fifo_almost_full,
  output logic                  o_fifo_wr_en,
  output logic [2*DW-1:0]       o_fifo_din,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [3:0]            o_state
);

  localparam int CNT_W = (LANES > 2) ? $clog2(LANES/2) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(LANES/2 - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_k;
  logic             w_wr;
  logic             w_capture;

  always_ff @(posedge i_bus_clk) begin
    if (i_srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_start) w_state_nxt = ST_ARMED;
        ST_ARMED: if (w_capture) w_state_nxt = ST_SEND;
        ST_SEND:  if (w_wr && (r_k == K_LAST)) w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort and reset both suppress the write in the cycle they are seen.
  always_comb begin
    w_wr         = (r_state == ST_SEND) && !i_fifo_almost_full && !i_abort && !i_srst;
    w_capture    = (r_state == ST_ARMED) && (&i_res_valid) && !i_abort;
    o_fifo_wr_en = w_wr;
    o_busy       = (r_state == ST_ARMED) || (r_state == ST_SEND);
    o_done       = (r_state == ST_DONE);
    o_state      = r_state;
  end

  always_ff @(posedge i_bus_clk) begin
    if (i_srst || i_abort) begin
      r_k <= '0;
    end else if (w_capture) begin
      r_k <= '0;
    end else if (w_wr && (r_k != K_LAST)) begin
      r_k <= r_k + CNT_W'(1);
    end
  end

  lane_pair_mux #(
    .LANES (LANES),
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_lane_pair_mux (
    .i_clk      (i_bus_clk),
    .i_capture  (w_capture),
    .i_res_data (i_res_data),
    .i_k        (r_k),
    .o_word     (o_fifo_din)
  );

endmodule
